// File: rtl/pc_branch_seq.sv
// rtl/pc_branch_seq.sv - program counter with fixed 3-cycle conditional branch sequencer
// Optional link register for brl is built when LINK_REG_EN is defined.
module pc_branch_seq #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4),
  parameter logic [4:0]          OPC_BR   = 5'd19,
  parameter logic [4:0]          OPC_BRL  = 5'd20
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                fetch_inc,
  input  logic                br_start,
  input  logic [31:0]         ir,
  input  logic                con_in,
  input  logic [PC_WIDTH-1:0] bus_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                br_busy,
  output logic                br_done,
  output logic                br_taken,
  output logic [PC_WIDTH-1:0] link_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [4:0]          opcode;
  logic                br_valid;
  logic                con_ff;
  logic [PC_WIDTH-1:0] pc_q;
  logic                taken_q;
  logic                unused_ir;

  assign opcode    = ir[31:27];
  assign br_valid  = br_start && ((opcode == OPC_BR) || (opcode == OPC_BRL));
  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    br_busy   = 1'b0;
    br_done   = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        br_busy   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        br_busy   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        br_busy   = 1'b1;
        br_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A valid branch in IDLE takes priority over a simultaneous fetch increment.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      con_ff  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (br_valid) begin
            taken_q <= 1'b0;
          end else if (fetch_inc) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        EVAL: con_ff <= con_in;
        LOAD: begin
          if (con_ff) begin
            pc_q    <= bus_in;
            taken_q <= 1'b1;
          end else begin
            taken_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign br_taken = taken_q;

`ifdef LINK_REG_EN
  logic                is_brl;
  logic [PC_WIDTH-1:0] link_q;

  // The pre-branch PC is saved in EVAL regardless of the branch outcome.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      is_brl <= 1'b0;
      link_q <= '0;
    end else begin
      if ((state == IDLE) && br_valid) begin
        is_brl <= (opcode == OPC_BRL);
      end
      if ((state == EVAL) && is_brl) begin
        link_q <= pc_q;
      end
    end
  end

  assign link_out = link_q;
`else
  assign link_out = '0;
`endif

endmodule

// File: tb/tb_pc_branch_seq.sv
// tb/tb_pc_branch_seq.sv - directed and randomized checks of pc_branch_seq against a cycle-offset model
module tb_pc_branch_seq;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        fetch_inc = 1'b0;
  logic        br_start = 1'b0;
  logic [31:0] ir = '0;
  logic        con_in = 1'b0;
  logic [31:0] bus_in = '0;
  logic [31:0] pc_out;
  logic        br_busy;
  logic        br_done;
  logic        br_taken;
  logic [31:0] link_out;

  int checks = 0;
  int failures = 0;

  // Reference model: a branch is tracked by its offset in cycles since acceptance.
  logic [31:0] m_pc;
  logic        m_taken;
  logic [31:0] m_link;
  logic        m_brl;
  logic        m_con;
  int          m_off;

  pc_branch_seq dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .fetch_inc (fetch_inc),
    .br_start  (br_start),
    .ir        (ir),
    .con_in    (con_in),
    .bus_in    (bus_in),
    .pc_out    (pc_out),
    .br_busy   (br_busy),
    .br_done   (br_done),
    .br_taken  (br_taken),
    .link_out  (link_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_taken = 1'b0;
    m_link  = 32'h0;
    m_brl   = 1'b0;
    m_con   = 1'b0;
    m_off   = 0;
  endtask

  task automatic model_step();
    logic [4:0] opc;
    opc = ir[31:27];
    if (m_off == 0) begin
      if (br_start && (opc == 5'd19 || opc == 5'd20)) begin
        m_off   = 1;
        m_taken = 1'b0;
        m_brl   = (opc == 5'd20);
      end else if (fetch_inc) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (m_off == 1) begin
      m_con = con_in;
`ifdef LINK_REG_EN
      if (m_brl) m_link = m_pc;
`endif
      m_off = 2;
    end else if (m_off == 2) begin
      if (m_con) m_pc = bus_in;
      m_taken = m_con;
      m_off   = 3;
    end else begin
      m_off = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_out,   m_pc);
    check({tag, ".busy"},  32'(br_busy),  32'(m_off != 0));
    check({tag, ".done"},  32'(br_done),  32'(m_off == 3));
    check({tag, ".taken"}, 32'(br_taken), 32'(m_taken));
    check({tag, ".link"},  link_out, m_link);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    clr_n     = 1'b1;
    fetch_inc = 1'b0;
    br_start  = 1'b0;
  endtask

  task automatic branch(input logic [4:0] opc, input logic con, input logic [31:0] tgt, input string tag);
    ir       = {opc, 27'($urandom)};
    br_start = 1'b1;
    tick({tag, ".accept"});
    br_start = 1'b0;
    con_in   = con;
    bus_in   = 32'($urandom);
    tick({tag, ".eval"});
    con_in   = 1'($urandom);
    bus_in   = tgt;
    tick({tag, ".load"});
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset0");
    @(negedge clk);
    clr_n = 1'b1;

    // Fetch increments from reset
    fetch_inc = 1'b1;
    tick("fetch1"); check("fetch1.const", pc_out, 32'd4);
    tick("fetch2"); check("fetch2.const", pc_out, 32'd8);
    tick("fetch3"); check("fetch3.const", pc_out, 32'd12);
    fetch_inc = 1'b0;

    // Reset while busy clears everything without a clock edge
    ir = {5'd19, 27'd0};
    br_start = 1'b1;
    tick("pre_rst");
    br_start = 1'b0;
    mid_reset("rst_mid");
    check("rst_mid.pc_const", pc_out, 32'h0);

    // Taken br from pc=8 to 0x100, with a one-cycle br_done pulse
    fetch_inc = 1'b1;
    tick("to8a");
    tick("to8b");
    fetch_inc = 1'b0;
    branch(5'd19, 1'b1, 32'h100, "br_t");
    check("br_t.pc_const", pc_out, 32'h100);
    check("br_t.taken_const", 32'(br_taken), 32'd1);
    check("br_t.done_const", 32'(br_done), 32'd1);
    tick("br_t.after");
    check("br_t.done_drop", 32'(br_done), 32'd0);

    // PC wrap at the top of the address space
    branch(5'd19, 1'b1, 32'hFFFF_FFFC, "br_wrap");
    tick("br_wrap.done");
    fetch_inc = 1'b1;
    tick("wrap");
    check("wrap.const", pc_out, 32'h0);
    fetch_inc = 1'b0;

    // Not-taken br with fetch_inc held high throughout
    mid_reset("rst_nt");
    fetch_inc = 1'b1;
    tick("nt8a");
    tick("nt8b");
    branch(5'd19, 1'b0, 32'hDEAD_BEE0, "br_nt");
    check("br_nt.pc_const", pc_out, 32'd8);
    check("br_nt.taken_const", 32'(br_taken), 32'd0);
    fetch_inc = 1'b0;
    tick("br_nt.after");

    // brl from 0x40 to 0x200
    branch(5'd19, 1'b1, 32'h40, "to40");
    tick("to40.done");
    branch(5'd20, 1'b1, 32'h200, "brl");
    check("brl.pc_const", pc_out, 32'h200);
`ifdef LINK_REG_EN
    check("brl.link_const", link_out, 32'h40);
`else
    check("brl.link_const", link_out, 32'h0);
`endif
    tick("brl.after");

    // Abort in LOAD
    ir = {5'd19, 27'd5};
    br_start = 1'b1;
    tick("ab.accept");
    br_start = 1'b0;
    con_in = 1'b1;
    bus_in = 32'h777;
    tick("ab.eval");
    check("ab.in_load", 32'(br_busy), 32'd1);
    mid_reset("ab.rst");
    tick("ab.idle");

    // Illegal opcode is ignored
    ir = {5'd3, 27'd0};
    br_start = 1'b1;
    tick("illegal");
    check("illegal.busy_const", 32'(br_busy), 32'd0);
    br_start = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] opc;
      case ($urandom_range(0, 3))
        0: opc = 5'd19;
        1: opc = 5'd20;
        2: opc = 5'd3;
        default: opc = 5'($urandom);
      endcase
      fetch_inc = 1'($urandom);
      br_start  = ($urandom_range(0, 2) == 0);
      ir        = {opc, 27'($urandom)};
      con_in    = 1'($urandom);
      bus_in    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom} & 32'hFFFF_FFFC;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
